// File: rtl/uart_program_loader.sv
// uart_program_loader: receives 8N1 bytes on rx and writes them into CPU
// memory, first INST_BYTES instruction bytes from address 0, then PIXEL_BYTES
// pixel bytes from PIXEL_BASE, then releases the CPU.
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-low reset
//   rx             in   UART serial input (idle high, asynchronous)
//   programAddress out  memory write address
//   programByte    out  memory write data
//   programWrEn    out  one-cycle write strobe
//   startProgram   out  high once loading is complete
//   cpuHold        out  high while loading
//   frameError     out  sticky, set on a stop bit sampled low
module uart_program_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned INST_BYTES   = 202,
  parameter int unsigned PIXEL_BASE   = 256,
  parameter int unsigned PIXEL_BYTES  = 200005
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [31:0] programAddress,
  output logic [7:0]  programByte,
  output logic        programWrEn,
  output logic        startProgram,
  output logic        cpuHold,
  output logic        frameError
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [31:0] INST_N   = 32'(INST_BYTES);
  localparam logic [31:0] PIX_N    = 32'(PIXEL_BYTES);
  localparam logic [31:0] PIX_BASE = 32'(PIXEL_BASE);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {LD_INST, LD_PIX, LD_RUN} ld_state_t;

  // With no instruction bytes the loader begins directly in the pixel region.
  localparam ld_state_t   LD_INIT   = (INST_BYTES == 0) ? LD_PIX : LD_INST;
  localparam logic [31:0] ADDR_INIT = (INST_BYTES == 0) ? PIX_BASE : 32'd0;

  logic             r_rx_meta;
  logic             r_rxs;
  rx_state_t        r_rx_state;
  rx_state_t        w_rx_state_nxt;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_byte_valid;
  logic [7:0]       r_byte;
  logic             r_frame_err;
  logic             w_cnt_clr;
  logic             w_shift_en;
  logic             w_byte_done;
  logic             w_stop_bad;

  ld_state_t        r_ld_state;
  ld_state_t        w_ld_state_nxt;
  logic             w_accept;
  logic [31:0]      r_addr;
  logic [31:0]      r_count;
  logic [31:0]      r_prog_addr;
  logic [7:0]       r_prog_byte;
  logic             r_wr_en;
  logic             r_start;
  logic             r_hold;

  // Two-flop synchroniser for the asynchronous rx line.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rxs     <= r_rx_meta;
    end
  end

  // RX state register.
  always_ff @(posedge clk) begin
    if (!reset) r_rx_state <= RX_IDLE;
    else        r_rx_state <= w_rx_state_nxt;
  end

  // RX next state and sampling strobes.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_cnt_clr      = 1'b0;
    w_shift_en     = 1'b0;
    w_byte_done    = 1'b0;
    w_stop_bad     = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_cnt_clr = 1'b1;
        if (!r_rxs) w_rx_state_nxt = RX_START;
      end
      RX_START: begin
        // Re-check mid start bit so short low pulses are rejected.
        if (r_clk_cnt == CNT_HALF) begin
          w_cnt_clr      = 1'b1;
          w_rx_state_nxt = r_rxs ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_clk_cnt == CNT_LAST) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_idx == 3'd7) w_rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_clk_cnt == CNT_LAST) begin
          w_cnt_clr      = 1'b1;
          w_rx_state_nxt = RX_IDLE;
          if (r_rxs) w_byte_done = 1'b1;
          else       w_stop_bad  = 1'b1;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  // RX datapath: bit timer, shift register, byte strobe, framing error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_clk_cnt    <= '0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'd0;
      r_byte_valid <= 1'b0;
      r_byte       <= 8'd0;
      r_frame_err  <= 1'b0;
    end else begin
      r_clk_cnt    <= w_cnt_clr ? '0 : CNT_W'(r_clk_cnt + 1'b1);
      r_byte_valid <= w_byte_done;
      if (r_rx_state != RX_DATA) r_bit_idx <= 3'd0;
      else if (w_shift_en)       r_bit_idx <= r_bit_idx + 3'd1;
      if (w_shift_en)  r_shift <= {r_rxs, r_shift[7:1]};
      if (w_byte_done) r_byte  <= r_shift;
      if (w_stop_bad)  r_frame_err <= 1'b1;
    end
  end

  // Loader state register.
  always_ff @(posedge clk) begin
    if (!reset) r_ld_state <= LD_INIT;
    else        r_ld_state <= w_ld_state_nxt;
  end

  // Loader next state; the region switch happens on its last write.
  always_comb begin
    w_ld_state_nxt = r_ld_state;
    w_accept       = 1'b0;
    case (r_ld_state)
      LD_INST: begin
        if (r_byte_valid) begin
          w_accept = 1'b1;
          if (32'(r_count + 32'd1) == INST_N)
            w_ld_state_nxt = (PIX_N == 32'd0) ? LD_RUN : LD_PIX;
        end
      end
      LD_PIX: begin
        if (r_byte_valid) begin
          w_accept = 1'b1;
          if (32'(r_count + 32'd1) == PIX_N) w_ld_state_nxt = LD_RUN;
        end
      end
      default: w_ld_state_nxt = LD_RUN;
    endcase
  end

  // Loader datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr      <= ADDR_INIT;
      r_count     <= 32'd0;
      r_prog_addr <= 32'd0;
      r_prog_byte <= 8'd0;
      r_wr_en     <= 1'b0;
      r_start     <= 1'b0;
      r_hold      <= 1'b1;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_prog_addr <= r_addr;
        r_prog_byte <= r_byte;
        if (w_ld_state_nxt != r_ld_state) begin
          r_addr  <= PIX_BASE;
          r_count <= 32'd0;
        end else begin
          r_addr  <= r_addr + 32'd1;
          r_count <= r_count + 32'd1;
        end
      end
      // Follows the state one cycle late, i.e. the cycle after the last write.
      r_start <= (r_ld_state == LD_RUN);
      r_hold  <= (r_ld_state != LD_RUN);
    end
  end

  assign programAddress = r_prog_addr;
  assign programByte    = r_prog_byte;
  assign programWrEn    = r_wr_en;
  assign startProgram   = r_start;
  assign cpuHold        = r_hold;
  assign frameError     = r_frame_err;

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader with a small configuration.
module tb_uart_program_loader;

  localparam int CPB   = 8;
  localparam int INST  = 4;
  localparam int PBASE = 16;
  localparam int PIX   = 3;
  localparam int TOTAL = INST + PIX;
  localparam int LAT   = 3 + CPB / 2 + 9 * CPB + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] programAddress;
  logic [7:0]  programByte;
  logic        programWrEn;
  logic        startProgram;
  logic        cpuHold;
  logic        frameError;

  uart_program_loader #(
    .CLKS_PER_BIT(CPB), .INST_BYTES(INST), .PIXEL_BASE(PBASE), .PIXEL_BYTES(PIX)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .programAddress(programAddress), .programByte(programByte),
    .programWrEn(programWrEn), .startProgram(startProgram),
    .cpuHold(cpuHold), .frameError(frameError)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [39:0] exp_q[$];
  logic [39:0] m_e;
  int          n_acc = 0;
  bit          fe_exp = 1'b0;
  int          seen = 0;
  bit          done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: the n-th accepted byte goes to n (instructions) or PBASE+n-INST (pixels).
  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    logic [31:0] a;
    if (!stop_ok) fe_exp = 1'b1;
    else if (n_acc < TOTAL) begin
      a = (n_acc < INST) ? 32'(n_acc) : 32'(PBASE + n_acc - INST);
      exp_q.push_back({a, b});
      n_acc++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    model_byte(b, stop_ok);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic glitch();
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    chk("queue_drained_before_reset", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    n_acc = 0; fe_exp = 1'b0; seen = 0; done = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_addr", programAddress, 32'd0);
    chk("rst_byte", 32'(programByte), 32'd0);
    chk("rst_wren", 32'(programWrEn), 32'd0);
    chk("rst_start", 32'(startProgram), 32'd0);
    chk("rst_hold", 32'(cpuHold), 32'd1);
    chk("rst_fe", 32'(frameError), 32'd0);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: pops expected writes and tracks release timing.
  always @(negedge clk) begin
    if (reset) begin
      chk("startProgram", 32'(startProgram), 32'(done));
      chk("cpuHold", 32'(cpuHold), 32'(!done));
      if (programWrEn) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual addr=%0h byte=%0h required none",
                   programAddress, programByte);
        end else begin
          m_e = exp_q.pop_front();
          chk("wr_addr", programAddress, m_e[39:8]);
          chk("wr_byte", 32'(programByte), 32'(m_e[7:0]));
        end
        seen++;
        if (seen == TOTAL) done = 1'b1;
      end
    end
  end

  initial begin
    int nb;
    logic [7:0] rb;
    bit ok;
    do_reset();

    // First byte with exact latency from start-bit edge to write strobe.
    fork
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (n < 200) begin
          @(posedge clk);
          n++;
          #1;
          if (programWrEn) break;
        end
        chk("first_write_latency", 32'(n), 32'(LAT));
      end
    join_none
    send_byte(8'hA5, 1'b1);
    chk("after_a5_start", 32'(startProgram), 32'd0);
    chk("after_a5_hold", 32'(cpuHold), 32'd1);

    // Full load, then bytes in RUN are ignored.
    do_reset();
    for (int i = 0; i < TOTAL; i++) send_byte(8'(8'h10 + i), 1'b1);
    chk("loaded_start", 32'(startProgram), 32'd1);
    send_byte(8'hFF, 1'b1);
    chk("run_start_kept", 32'(startProgram), 32'd1);
    glitch();
    chk("glitch_no_fe", 32'(frameError), 32'd0);

    // Framing error is sticky and does not advance the address.
    do_reset();
    glitch();
    chk("glitch_no_fe2", 32'(frameError), 32'd0);
    send_byte(8'h3C, 1'b0);
    chk("fe_set", 32'(frameError), 32'd1);
    send_byte(8'h55, 1'b1);
    chk("fe_sticky", 32'(frameError), 32'd1);

    // Reset mid-load restarts at address 0.
    do_reset();
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    do_reset();
    send_byte(8'h77, 1'b1);

    // Randomized rounds with occasional bad stop bits.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      nb = $urandom_range(3, 10);
      for (int k = 0; k < nb; k++) begin
        rb = 8'($urandom);
        ok = ($urandom_range(0, 5) != 0);
        send_byte(rb, ok);
      end
      chk("rand_fe", 32'(frameError), 32'(fe_exp));
    end

    repeat (4 * CPB) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Hardware front end that fills CPU instruction memory and pixel memory over a UART link before the CPU runs.
- Deserialises 8N1 bytes from `rx` and writes them to the CPU memory write port (`programAddress`/`programByte`/`programWrEn`) as two regions:
  - instruction bytes from address 0;
  - pixel bytes from PIXEL_BASE.
- Then releases the CPU via `startProgram` and `cpuHold`.
- Sits directly upstream of the CPU top-level memory-load port.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 4.
- INST_BYTES, 202, number of instruction bytes, loaded at addresses 0..INST_BYTES-1.
- PIXEL_BASE, 256, address of the first pixel byte.
- PIXEL_BYTES, 200005, number of pixel bytes, loaded at PIXEL_BASE..PIXEL_BASE+PIXEL_BYTES-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- rx  in  1  UART serial input, idle high, asynchronous to clk.
- programAddress  out  32  memory write address.
- programByte  out  8  memory write data.
- programWrEn  out  1  one-cycle write strobe; address and byte valid while high.
- startProgram  out  1  goes high and stays high once loading completes.
- cpuHold  out  1  1 while loading; CPU is held in reset while this is 1.
- frameError  out  1  sticky; set on any stop bit sampled as 0.

Behaviour:
- Reset values (reset=0 at a clock edge):
  - programAddress=0, programByte=0, programWrEn=0, startProgram=0.
  - cpuHold=1, frameError=0.
  - Both FSMs return to their initial states; byte counter=0.
- Reset mid-load discards all progress; the next received byte is written to address 0.

RX input:
- `rx` passes through a 2-flop synchroniser (reset value 1); all RX logic uses the synchronised signal `rxs`.

RX FSM (bit counter 0..CLKS_PER_BIT-1):
- IDLE: on rxs==0 -> START, counter cleared.
- START: at counter==CLKS_PER_BIT/2-1, re-sample rxs.
  - rxs==0 -> DATA, counter cleared.
  - rxs==1 -> IDLE (glitch, no byte).
- DATA: sample rxs at counter==CLKS_PER_BIT-1 into shift register, LSB first; after 8 bits -> STOP.
- STOP: sample rxs at counter==CLKS_PER_BIT-1.
  - 1: assert internal byteValid for exactly one cycle with the data byte.
  - 0: set frameError, produce no byte.
  - Either way -> IDLE the next cycle.

Loader FSM states: LOAD_INST, LOAD_PIX, RUN. Initial state is LOAD_INST, addr=0, count=0.
- byteValid in LOAD_INST or LOAD_PIX (next edge):
  - programAddress<=addr, programByte<=byte, programWrEn<=1.
  - addr and count increment.
- programWrEn is high exactly 1 cycle per accepted byte. Latency is 1 cycle from byteValid, i.e. 2 cycles after the stop-bit sample edge.
- LOAD_INST, count reaches INST_BYTES with this write: -> LOAD_PIX, addr<=PIXEL_BASE, count<=0.
- LOAD_PIX, count reaches PIXEL_BYTES with this write: -> RUN.
  - startProgram<=1 and cpuHold<=0 on the cycle after the final programWrEn pulse.
- RUN: further byteValid ignored, no writes. startProgram stays 1 and cpuHold stays 0 until reset.
- Address arithmetic is 32-bit, no wrap expected.
- frameError does not stall loading and does not advance the address.
- If INST_BYTES==0, the FSM starts directly in LOAD_PIX at PIXEL_BASE.

Test Plan (CLKS_PER_BIT=8, INST_BYTES=4, PIXEL_BASE=16, PIXEL_BYTES=3):
- Send 0xA5 after reset:
  - one programWrEn pulse with programAddress=0, programByte=0xA5;
  - pulse occurs 2 cycles after stop-bit sample;
  - startProgram=0, cpuHold=1.
- Send 0x10..0x16:
  - writes (0,0x10),(1,0x11),(2,0x12),(3,0x13),(16,0x14),(17,0x15),(18,0x16);
  - startProgram=1 and cpuHold=0 on the cycle after the 7th pulse.
- After full load, send 0xFF -> no programWrEn; startProgram remains 1.
- rx low for 2 cycles then high -> no byte, no write, frameError=0.
- Byte 0x3C with stop bit 0 -> no write, frameError=1. Next valid byte 0x55 is written to address 0 and frameError stays 1.
- Load 0x01, 0x02, assert reset=0 for 1 cycle, then send 0x77:
  - write (0,0x77);
  - all outputs at reset values during reset.
